// File: rtl/full_adder.sv
// Ripple-carry full adder built from 1-bit cells. Outputs can be registered
// (1-cycle latency) or driven combinationally.
module full_adder #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned OUT_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i0,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_d;
  logic             carry_out_d;

  // Carry is threaded through a local variable so the chain stays one
  // combinational process instead of a self-referencing vector.
  always_comb begin
    logic c;
    c     = carry_in;
    sum_d = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      sum_d[k] = i0[k] ^ i1[k] ^ c;
      c        = (i0[k] & i1[k]) | (i0[k] & c) | (i1[k] & c);
    end
    carry_out_d = c;
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [WIDTH-1:0] sum_q;
      logic             carry_out_q;
      logic             out_valid_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sum_q       <= '0;
          carry_out_q <= 1'b0;
          out_valid_q <= 1'b0;
        end else begin
          sum_q       <= sum_d;
          carry_out_q <= carry_out_d;
          out_valid_q <= in_valid;
        end
      end

      assign sum       = sum_q;
      assign carry_out = carry_out_q;
      assign out_valid = out_valid_q;
    end else begin : g_comb
      assign sum       = sum_d;
      assign carry_out = carry_out_d;
      assign out_valid = in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder.sv
// Checks combinational and registered adder configurations against a
// truth table and a delayed arithmetic scoreboard.
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cin = 1'b0;
  logic       vin = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic       c1_sum, c1_co, c1_ov;
  logic       r1_sum, r1_co, r1_ov;
  logic [3:0] r4_sum;
  logic       r4_co, r4_ov;
  logic [7:0] r8_sum;
  logic       r8_co, r8_ov;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0] res;
    logic       v;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1), .OUT_REG(0)) u_c1 (
    .clk(clk), .rst_n(rst_n), .carry_in(cin), .i1(a[0:0]), .i0(b[0:0]),
    .in_valid(vin), .sum(c1_sum), .carry_out(c1_co), .out_valid(c1_ov));

  full_adder #(.WIDTH(1), .OUT_REG(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .carry_in(cin), .i1(a[0:0]), .i0(b[0:0]),
    .in_valid(vin), .sum(r1_sum), .carry_out(r1_co), .out_valid(r1_ov));

  full_adder #(.WIDTH(4), .OUT_REG(1)) u_r4 (
    .clk(clk), .rst_n(rst_n), .carry_in(cin), .i1(a[3:0]), .i0(b[3:0]),
    .in_valid(vin), .sum(r4_sum), .carry_out(r4_co), .out_valid(r4_ov));

  full_adder #(.WIDTH(8), .OUT_REG(1)) u_r8 (
    .clk(clk), .rst_n(rst_n), .carry_in(cin), .i1(a), .i0(b),
    .in_valid(vin), .sum(r8_sum), .carry_out(r8_co), .out_valid(r8_ov));

  // Drive one vector at the falling edge and queue what each registered
  // instance must show after the next rising edge.
  task automatic drive(input logic [7:0] ai, input logic [7:0] bi,
                       input logic ci, input logic vi);
    exp_t e;
    logic [8:0] full;
    @(negedge clk);
    a = ai; b = bi; cin = ci; vin = vi;
    full = {1'b0, ai} + {1'b0, bi} + {8'd0, ci};
    e.v = vi & rst_n;
    e.res = {8'd0, ai[0] ^ bi[0] ^ ci} |
            {7'd0, (ai[0] & bi[0]) | (ai[0] & ci) | (bi[0] & ci), 1'b0};
    if (!rst_n) e.res = '0;
    q1.push_back(e);
    e.res = rst_n ? {4'd0, {1'b0, ai[3:0]} + {1'b0, bi[3:0]} + {4'd0, ci}} : 9'd0;
    q4.push_back(e);
    e.res = rst_n ? full : 9'd0;
    q8.push_back(e);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({r1_sum, r1_co, r1_ov, r4_sum, r4_co, r4_ov, r8_sum, r8_co, r8_ov} !== '0) begin
      errors++;
      $display("FAIL reset_state: got r1=%b%b%b r4=%h%b%b r8=%h%b%b, want all zero",
               r1_sum, r1_co, r1_ov, r4_sum, r4_co, r4_ov, r8_sum, r8_co, r8_ov);
    end
  endtask

  task automatic test_comb_truth_table;
    logic [1:0] tbl [8];
    tbl = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      cin = v[2]; a = {7'd0, v[1]}; b = {7'd0, v[0]}; vin = v[0];
      #1;
      checks++;
      if ({c1_sum, c1_co, c1_ov} !== {tbl[i], v[0]}) begin
        errors++;
        $display("FAIL comb_tt[%0d]: got sum,co,ov=%b%b%b want %b%b",
                 i, c1_sum, c1_co, c1_ov, tbl[i], v[0]);
      end
    end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    if (q1.size() == 0) begin
      errors++;
      $display("FAIL %s_r1: scoreboard empty", name);
    end else begin
      e = q1.pop_front();
      if ({r1_co, r1_sum, r1_ov} !== {e.res[1:0], e.v}) begin
        errors++;
        $display("FAIL %s_r1: got co,sum,ov=%b%b%b want %b%b", name,
                 r1_co, r1_sum, r1_ov, e.res[1:0], e.v);
      end
    end
    checks++;
    if (q4.size() == 0) begin
      errors++;
      $display("FAIL %s_r4: scoreboard empty", name);
    end else begin
      e = q4.pop_front();
      if ({r4_co, r4_sum, r4_ov} !== {e.res[4:0], e.v}) begin
        errors++;
        $display("FAIL %s_r4: got co=%b sum=%h ov=%b want %h ov=%b", name,
                 r4_co, r4_sum, r4_ov, e.res[4:0], e.v);
      end
    end
    checks++;
    if (q8.size() == 0) begin
      errors++;
      $display("FAIL %s_r8: scoreboard empty", name);
    end else begin
      e = q8.pop_front();
      if ({r8_co, r8_sum, r8_ov} !== {e.res, e.v}) begin
        errors++;
        $display("FAIL %s_r8: got co=%b sum=%h ov=%b want %h ov=%b", name,
                 r8_co, r8_sum, r8_ov, e.res, e.v);
      end
    end
  endtask

  task automatic test_reg_truth_table;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      drive({7'd0, v[1]}, {7'd0, v[0]}, v[2], 1'b1);
      pop_check("reg_tt");
    end
  endtask

  task automatic test_reset_midstream;
    @(negedge clk);
    rst_n = 1'b0;
    drive(8'h01, 8'h01, 1'b1, 1'b1);
    pop_check("rst_assert");
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h01, 8'h01, 1'b1, 1'b1);
    pop_check("rst_release");
    checks++;
    if ({r1_sum, r1_co} !== 2'b11) begin
      errors++;
      $display("FAIL rst_release_direct: got sum,co=%b%b want 11", r1_sum, r1_co);
    end
  endtask

  task automatic test_ripple4;
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic       tc [3];
    ta = '{8'h0F, 8'h07, 8'h05};
    tb = '{8'h01, 8'h08, 8'h0A};
    tc = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(ta[i], tb[i], tc[i], 1'b1);
      pop_check("ripple4");
    end
  endtask

  task automatic test_valid_tracking;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    pop_check("valid_pre");
    for (int i = 0; i < 4; i++) begin
      drive(8'(i * 37), 8'(i * 91 + 5), i[0], pat[i]);
      pop_check("valid_trk");
    end
  endtask

  task automatic test_back_to_back_random;
    for (int i = 0; i < 1000; i++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      pop_check("random");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    test_reset;
    test_comb_truth_table;
    @(negedge clk);
    rst_n = 1'b1;
    test_reg_truth_table;
    test_reset_midstream;
    test_ripple4;
    test_valid_tracking;
    test_back_to_back_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
